// File: rtl/keccak_pkg.sv
// Shared types and constants for the keccak message feeder slice.
package keccak_pkg;

    localparam int WORD_BYTES   = 8;
    localparam int WORD_W       = 8 * WORD_BYTES;
    localparam int BYTE_NUM_W   = 3;
    localparam int COUNT_W      = 4;
    localparam int DEF_DIGEST_W = 512;

    // Byte count at which a word is complete and must be handed to the core
    localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(WORD_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        FILL,
        SEND,
        PAD,
        WAIT
    } feeder_state_t;

    // Right-shift distance that moves a byte from the top lane down to lane 'lane'
    function automatic logic [5:0] lane_shift(input logic [BYTE_NUM_W-1:0] lane);
        return {lane, 3'b000};
    endfunction

endpackage

// File: rtl/keccak_byte_packer.sv
// Packs bytes big-endian into a 64-bit word; the first byte lands in [63:56].
module keccak_byte_packer
    import keccak_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    output logic [WORD_W-1:0]  word,
    output logic [COUNT_W-1:0] count
);

    logic [WORD_W-1:0] lane_bits;

    // Place the incoming byte in the lane selected by the current count
    always_comb begin
        lane_bits = {wr_data, {(WORD_W-8){1'b0}}} >> lane_shift(count[BYTE_NUM_W-1:0]);
    end

    // Word starts zeroed and lanes are OR-ed in, so unused lanes stay zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word  <= '0;
            count <= '0;
        end else if (clear) begin
            word  <= '0;
            count <= '0;
        end else if (wr_en) begin
            word  <= word | lane_bits;
            count <= count + COUNT_W'(1);
        end
    end

endmodule

// File: rtl/keccak_msg_feeder.sv
// Byte-stream front end for the keccak core: per-message core reset, word
// packing with final-word padding, backpressure and digest capture.
module keccak_msg_feeder
    import keccak_pkg::*;
#(
    parameter int RST_CYCLES = 1,
    parameter int DIGEST_W   = DEF_DIGEST_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    input  logic                  s_null,
    output logic                  s_ready,
    output logic                  k_reset,
    output logic [WORD_W-1:0]     k_in,
    output logic                  k_in_ready,
    output logic                  k_is_last,
    output logic [BYTE_NUM_W-1:0] k_byte_num,
    input  logic                  k_buffer_full,
    input  logic [DIGEST_W-1:0]   k_out,
    input  logic                  k_out_ready,
    output logic [DIGEST_W-1:0]   digest,
    output logic                  done,
    output logic                  busy
);

    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

    feeder_state_t             state;
    feeder_state_t             state_next;
    logic [3:0]                rst_cnt;
    logic                      pad_flag;
    logic                      pad_next;
    logic                      is_last_next;
    logic [BYTE_NUM_W-1:0]     byte_num_next;
    logic                      pack_clear;
    logic [WORD_W-1:0]         pack_word;
    logic [COUNT_W-1:0]        pack_count;
    logic [COUNT_W-1:0]        count_after;
    logic                      accept;
    logic                      take_null;
    logic                      write_byte;
    logic                      xfer;
    logic                      capture;

    // Handshake qualifiers; a null-terminating beat is consumed but never written
    assign accept      = s_valid & s_ready;
    assign take_null   = s_null & s_last;
    assign write_byte  = accept & ~take_null;
    assign count_after = pack_count + COUNT_W'(write_byte);
    assign xfer        = k_in_ready & ~k_buffer_full;
    assign capture     = (state == WAIT) & k_out_ready;

    keccak_byte_packer u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (pack_clear),
        .wr_en   (write_byte),
        .wr_data (s_data),
        .word    (pack_word),
        .count   (pack_count)
    );

    assign k_in = pack_word;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counts cycles spent holding the core in reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt <= '0;
        end else if (state == CRST) begin
            rst_cnt <= rst_cnt + 4'd1;
        end else begin
            rst_cnt <= '0;
        end
    end

    // Next state plus next values of the word qualifiers presented to the core
    always_comb begin
        state_next    = state;
        pad_next      = pad_flag;
        is_last_next  = k_is_last;
        byte_num_next = k_byte_num;
        pack_clear    = 1'b0;
        case (state)
            IDLE: begin
                pack_clear = 1'b1;
                if (s_valid) begin
                    state_next = CRST;
                end
            end
            CRST: begin
                if (rst_cnt == RST_LAST) begin
                    state_next = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    if (s_last) begin
                        state_next = SEND;
                        if (count_after == FULL_COUNT) begin
                            pad_next      = 1'b1;
                            is_last_next  = 1'b0;
                            byte_num_next = '0;
                        end else begin
                            is_last_next  = 1'b1;
                            byte_num_next = count_after[BYTE_NUM_W-1:0];
                        end
                    end else if (count_after == FULL_COUNT) begin
                        state_next    = SEND;
                        is_last_next  = 1'b0;
                        byte_num_next = '0;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    pack_clear = 1'b1;
                    if (k_is_last) begin
                        state_next    = WAIT;
                        is_last_next  = 1'b0;
                        byte_num_next = '0;
                    end else if (pad_flag) begin
                        state_next    = PAD;
                        pad_next      = 1'b0;
                        is_last_next  = 1'b1;
                        byte_num_next = '0;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            PAD: begin
                if (xfer) begin
                    state_next    = WAIT;
                    is_last_next  = 1'b0;
                    byte_num_next = '0;
                end
            end
            WAIT: begin
                if (k_out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered handshake and word-qualifier outputs decoded from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_ready    <= 1'b0;
            k_reset    <= 1'b0;
            k_in_ready <= 1'b0;
            k_is_last  <= 1'b0;
            k_byte_num <= '0;
            pad_flag   <= 1'b0;
        end else begin
            s_ready    <= (state_next == FILL);
            k_reset    <= (state_next == CRST);
            k_in_ready <= (state_next == SEND) || (state_next == PAD);
            k_is_last  <= is_last_next;
            k_byte_num <= byte_num_next;
            pad_flag   <= pad_next;
        end
    end

    // Digest capture, done strobe and busy tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digest <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= capture;
            if (capture) begin
                digest <= k_out;
                busy   <= 1'b0;
            end else if (accept) begin
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Self-checking bench for keccak_msg_feeder; the bench plays the keccak core.
`timescale 1ns/1ps
module tb_keccak_msg_feeder;

    localparam int RST_CYC    = 3;
    localparam int DW         = 512;
    localparam int MSG_BUDGET = 2000;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       nul;
    } beat_t;

    typedef struct {
        string       name;
        string       text;
        logic [63:0] raw;
        int          raw_len;
        bit          term_null;
        int          stall_mode;
        int          exp_words;
        logic [67:0] exp_last;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_null;
    logic          s_ready;
    logic          k_reset;
    logic [63:0]   k_in;
    logic          k_in_ready;
    logic          k_is_last;
    logic [2:0]    k_byte_num;
    logic          k_buffer_full;
    logic [DW-1:0] k_out;
    logic          k_out_ready;
    logic [DW-1:0] digest;
    logic          done;
    logic          busy;

    int errors;
    int checks;

    keccak_msg_feeder #(
        .RST_CYCLES (RST_CYC),
        .DIGEST_W   (DW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_null        (s_null),
        .s_ready       (s_ready),
        .k_reset       (k_reset),
        .k_in          (k_in),
        .k_in_ready    (k_in_ready),
        .k_is_last     (k_is_last),
        .k_byte_num    (k_byte_num),
        .k_buffer_full (k_buffer_full),
        .k_out         (k_out),
        .k_out_ready   (k_out_ready),
        .digest        (digest),
        .done          (done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Global safety net against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [DW-1:0] actual,
                                input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "/s_ready"},    s_ready,    0);
        check_output({tag, "/k_reset"},    k_reset,    0);
        check_output({tag, "/k_in"},       k_in,       0);
        check_output({tag, "/k_in_ready"}, k_in_ready, 0);
        check_output({tag, "/k_is_last"},  k_is_last,  0);
        check_output({tag, "/k_byte_num"}, k_byte_num, 0);
        check_output({tag, "/digest"},     digest,     0);
        check_output({tag, "/done"},       done,       0);
        check_output({tag, "/busy"},       busy,       0);
    endtask

    function automatic logic [DW-1:0] rand_digest();
        logic [DW-1:0] d;
        d = '0;
        for (int i = 0; i < DW / 32; i++) begin
            d = {d[DW-33:0], 32'($urandom)};
        end
        return d;
    endfunction

    // Expected core words: whole 8-byte groups, then a partial word with
    // is_last and its byte count, or an empty last word when nothing is left over
    task automatic model_words(input byte_q_t msg, output logic [67:0] exp_q[$]);
        int n;
        int full;
        int rem;
        logic [63:0] w;
        exp_q.delete();
        n    = msg.size();
        full = n / 8;
        rem  = n % 8;
        for (int i = 0; i < full; i++) begin
            w = '0;
            for (int j = 0; j < 8; j++) w = {w[55:0], msg[8*i+j]};
            exp_q.push_back({w, 1'b0, 3'd0});
        end
        w = '0;
        for (int j = 0; j < 8; j++) w = {w[55:0], (j < rem) ? msg[8*full+j] : 8'h00};
        exp_q.push_back({w, 1'b1, 3'(rem)});
    endtask

    function automatic vec_t mk(input string n, input string t, input logic [63:0] raw,
                                input int rl, input bit tn, input int sm, input int ew,
                                input logic [63:0] lw, input logic ll, input logic [2:0] lb);
        vec_t v;
        v.name = n; v.text = t; v.raw = raw; v.raw_len = rl; v.term_null = tn;
        v.stall_mode = sm; v.exp_words = ew; v.exp_last = {lw, ll, lb};
        return v;
    endfunction

    // Drives one message as the byte source and answers as the core.
    // stall_mode: 0 none, 1 random gaps/backpressure/stray out_ready, 2 hold buffer_full 10 cycles
    task automatic apply_stimulus(input string tag, input byte_q_t msg, input bit term_null,
                                  input int stall_mode, output int n_words,
                                  output logic [67:0] last_rec);
        beat_t         beats[$];
        beat_t         b;
        logic [67:0]   exp_q[$];
        logic [67:0]   cur;
        logic [67:0]   prev_rec;
        logic [DW-1:0] dig;
        int  idx, rst_seen, wait_cnt, stall_cnt, cyc;
        bit  overlap, late_accept, bad_done, last_seen, ready_driven;
        bit  drop_pending, finished, prev_stalled;

        model_words(msg, exp_q);
        for (int i = 0; i < msg.size(); i++) begin
            b.data = msg[i];
            b.last = (!term_null && i == msg.size() - 1);
            b.nul  = 1'b0;
            beats.push_back(b);
        end
        if (term_null) begin
            b.data = 8'($urandom);
            b.last = 1'b1;
            b.nul  = 1'b1;
            beats.push_back(b);
        end

        dig = rand_digest();
        idx = 0; rst_seen = 0; wait_cnt = 0; stall_cnt = 0; cyc = 0;
        overlap = 0; late_accept = 0; bad_done = 0; last_seen = 0; ready_driven = 0;
        drop_pending = 0; finished = 0; prev_stalled = 0;
        prev_rec = '0; n_words = 0; last_rec = '0;
        k_buffer_full = 1'b0;
        k_out_ready   = 1'b0;

        while (!finished && cyc < MSG_BUDGET) begin
            @(negedge clk);
            cyc++;
            if (k_reset) rst_seen++;
            if (k_reset && s_ready) overlap = 1;
            if (drop_pending) begin
                check_output({tag, "/done_width"}, done, 0);
                finished = 1;
            end else if (ready_driven) begin
                check_output({tag, "/done"},    done,    1);
                check_output({tag, "/digest"},  digest,  dig);
                check_output({tag, "/busy_end"}, busy,   0);
                check_output({tag, "/s_ready_end"}, s_ready, 0);
                k_out_ready  = 1'b0;
                k_out        = rand_digest();
                ready_driven = 0;
                drop_pending = 1;
            end else begin
                if (done) bad_done = 1;
                if (last_seen && s_ready) late_accept = 1;
                cur = {k_in, k_is_last, k_byte_num};
                if (prev_stalled) begin
                    check_output({tag, "/stall_hold"}, {k_in_ready, cur, s_ready},
                                 {1'b1, prev_rec, 1'b0});
                end
                if (idx < beats.size() && (stall_mode != 1 || $urandom_range(0, 3) != 0)) begin
                    s_valid = 1'b1;
                    s_data  = beats[idx].data;
                    s_last  = beats[idx].last;
                    s_null  = beats[idx].nul;
                end else begin
                    s_valid = 1'b0;
                    s_data  = 8'($urandom);
                    s_last  = 1'b0;
                    s_null  = 1'b0;
                end
                if (s_valid && s_ready) idx++;
                if (last_seen) begin
                    k_buffer_full = 1'b0;
                    prev_stalled  = 0;
                    if (wait_cnt == 0) begin
                        k_out_ready  = 1'b1;
                        k_out        = dig;
                        ready_driven = 1;
                    end else begin
                        wait_cnt--;
                        k_out_ready = 1'b0;
                    end
                end else begin
                    case (stall_mode)
                        1: k_buffer_full = ($urandom_range(0, 2) == 0);
                        2: begin
                            k_buffer_full = k_in_ready && (stall_cnt < 10);
                            if (k_buffer_full) stall_cnt++;
                        end
                        default: k_buffer_full = 1'b0;
                    endcase
                    k_out_ready  = (stall_mode == 1) && ($urandom_range(0, 9) == 0);
                    k_out        = rand_digest();
                    prev_stalled = k_in_ready && k_buffer_full;
                    prev_rec     = cur;
                    if (k_in_ready && !k_buffer_full) begin
                        if (n_words < exp_q.size())
                            check_output({tag, "/word"}, cur, exp_q[n_words]);
                        else
                            check_output({tag, "/extra_word"}, 1, 0);
                        n_words++;
                        last_rec = cur;
                        if (k_is_last) begin
                            last_seen = 1;
                            wait_cnt  = $urandom_range(0, 2);
                            check_output({tag, "/busy_mid"}, busy, 1);
                        end
                    end
                end
            end
        end

        s_valid = 1'b0; s_last = 1'b0; s_null = 1'b0;
        k_out_ready = 1'b0; k_buffer_full = 1'b0;
        if (!finished) begin
            check_output({tag, "/timeout"}, 1, 0);
            reset_n = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
        end
        check_output({tag, "/n_words_model"}, n_words, exp_q.size());
        check_output({tag, "/k_reset_cycles"}, rst_seen, RST_CYC);
        check_output({tag, "/reset_overlap"}, overlap, 0);
        check_output({tag, "/late_accept"}, late_accept, 0);
        check_output({tag, "/stray_done"}, bad_done, 0);
    endtask

    initial begin
        vec_t        vecs[7];
        byte_q_t     msg;
        string       s;
        logic [63:0] r;
        int          nw;
        int          accepted;
        int          cyc;
        int          len;
        bit          tn;
        logic [67:0] lr;

        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; s_null = 1'b0;
        k_buffer_full = 1'b0; k_out = '0; k_out_ready = 1'b0;

        vecs[0] = mk("fox43", "The quick brown fox jumps over the lazy dog", 64'h0, 0, 1'b0, 0, 6,
                     64'h646F670000000000, 1'b1, 3'd3);
        vecs[1] = mk("fox44", "The quick brown fox jumps over the lazy dog.", 64'h0, 0, 1'b0, 0, 6,
                     64'h646F672E00000000, 1'b1, 3'd4);
        vecs[2] = mk("null", "", 64'h0, 0, 1'b1, 0, 1, 64'h0, 1'b1, 3'd0);
        vecs[3] = mk("eight", "", 64'h1234567890ABCDEF, 8, 1'b0, 0, 2, 64'h0, 1'b1, 3'd0);
        vecs[4] = mk("stall9", "ABCDEFGHI", 64'h0, 0, 1'b0, 2, 2, 64'h4900000000000000, 1'b1, 3'd1);
        vecs[5] = mk("null_after_bytes", "xyz", 64'h0, 0, 1'b1, 0, 1,
                     64'h78797A0000000000, 1'b1, 3'd3);
        vecs[6] = mk("seven", "", 64'hA1A2A3A4A5A6A700, 7, 1'b0, 0, 1,
                     64'hA1A2A3A4A5A6A700, 1'b1, 3'd7);

        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed vectors");
        for (int i = 0; i < 7; i++) begin
            msg.delete();
            if (vecs[i].raw_len > 0) begin
                r = vecs[i].raw;
                for (int j = 0; j < vecs[i].raw_len; j++) msg.push_back(r[63-8*j -: 8]);
            end else begin
                s = vecs[i].text;
                for (int j = 0; j < s.len(); j++) msg.push_back(8'(s[j]));
            end
            apply_stimulus(vecs[i].name, msg, vecs[i].term_null, vecs[i].stall_mode, nw, lr);
            check_output({vecs[i].name, "/n_words"}, nw, vecs[i].exp_words);
            check_output({vecs[i].name, "/last_word"}, lr, vecs[i].exp_last);
        end

        $display("[TB] reset in the middle of a message");
        accepted = 0;
        cyc = 0;
        while (accepted < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            s_data  = 8'(8'h10 + accepted);
            s_last  = 1'b0;
            s_null  = 1'b0;
            s_valid = 1'b1;
            if (s_ready) accepted++;
        end
        @(negedge clk);
        s_valid = 1'b0;
        check_output("abort/accepted", accepted, 5);
        check_output("abort/busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clk);
        reset_n = 1'b1;
        msg.delete();
        for (int j = 0; j < 20; j++) msg.push_back(8'($urandom));
        apply_stimulus("post_abort", msg, 1'b0, 0, nw, lr);

        $display("[TB] randomized messages");
        for (int i = 0; i < 25; i++) begin
            len = (i % 5 == 0) ? 8 * $urandom_range(1, 3) : $urandom_range(0, 30);
            tn  = (len == 0) ? 1'b1 : ($urandom_range(0, 4) == 0);
            msg.delete();
            for (int j = 0; j < len; j++) msg.push_back(8'($urandom));
            apply_stimulus("rand", msg, tn, 1, nw, lr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keccak_msg_feeder.md
Name: keccak_msg_feeder

Overview:
Transmit-side front end for the keccak core's word input port. It accepts a byte stream with a valid/ready handshake and packs it big-endian into 64-bit words. It drives the core's in/in_ready/is_last/byte_num interface with its own per-message core reset and honours buffer_full backpressure. It then waits for out_ready and presents the 512-bit digest with a one-cycle done strobe.

Parameters:
RST_CYCLES, 1, number of cycles k_reset is held high before the first word of each message (1..15)
DIGEST_W, 512, digest width passed through from the core

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
s_data  in  8  message byte
s_valid  in  1  s_data valid
s_last  in  1  qualifies the final byte of a message
s_null  in  1  with s_valid&s_last: empty message, s_data ignored
s_ready  out  1  feeder accepts a byte this cycle
k_reset  out  1  active-high synchronous reset to the core
k_in  out  64  word to the core; first byte in [63:56]
k_in_ready  out  1  word valid
k_is_last  out  1  final word of the message
k_byte_num  out  3  valid bytes in the final word (0..7); 0 when k_is_last=0
k_buffer_full  in  1  core cannot accept a word
k_out  in  DIGEST_W  core digest
k_out_ready  in  1  core digest valid
digest  out  DIGEST_W  captured digest
done  out  1  one-cycle pulse when digest updates
busy  out  1  high from first accepted byte until done

Behaviour:
- Reset (async assert, sync deassert): state IDLE. s_ready=0, k_reset=0, k_in=0, k_in_ready=0, k_is_last=0, k_byte_num=0, digest=0, done=0, busy=0. Byte counter and word register are 0.
- All outputs are registered. Word transfer occurs in a cycle where k_in_ready=1 and k_buffer_full=0. k_in, k_is_last and k_byte_num are held stable while k_in_ready=1 and transfer has not occurred.
- IDLE: s_ready=0. If s_valid=1, go to CRST. The byte is not consumed.
- CRST: k_reset=1 for RST_CYCLES cycles, then go to FILL with count=0.
- FILL: s_ready=1. On s_valid, the byte goes to lane [63-8*count -: 8] and count increments. busy is set on the first byte.
  - count reaches 8 and s_last=0: go to SEND (is_last=0).
  - count reaches 8 and s_last=1: go to SEND, then PAD.
  - s_last with count<8 after the write: SEND with is_last=1, byte_num=count. Unused lanes are zero.
  - s_null&s_last at count=0: SEND with k_in=0, is_last=1, byte_num=0.
  - s_null&s_last at count>0 is illegal. It is treated as s_last with the byte ignored.
- SEND: s_ready=0, k_in_ready=1. On transfer: if is_last, go to WAIT. Else if the pad flag is set, go to PAD. Else clear the word and count and go to FILL.
- PAD: present k_in=0, is_last=1, byte_num=0. On transfer, go to WAIT. A message whose length is a multiple of 8 therefore always ends with an empty last word.
- WAIT: k_in_ready=0. On k_out_ready=1, capture k_out into digest, pulse done, clear busy and go to IDLE.
- k_out_ready arriving in any state other than WAIT is ignored.
- Back-to-back messages: the next message gets a fresh k_reset sequence. No byte is accepted between is_last transfer and done.
- k_buffer_full held high indefinitely stalls SEND/PAD with outputs stable. No timeout.
- reset_n asserted mid-message aborts everything to reset values. The partial word is discarded and the digest is cleared.

Decomposition:
- Package keccak_pkg: state enum (IDLE, CRST, FILL, SEND, PAD, WAIT), WORD_BYTES=8, BYTE_NUM_W=3, DIGEST_W default.
- One sub-module, keccak_byte_packer: 8-to-64 big-endian shift/lane writer with count and zero-fill. The FSM and core handshake stay in the top.

Test Plan:
1. "The quick brown fox jumps over the lazy dog" (43 B) -> 5 words without is_last, 6th word "dog"+5 zero bytes with is_last=1 and byte_num=3; digest=d135bb84d0439dba…3c79659f609.
2. Same text plus "." (44 B) -> last word "dog."+zeros with byte_num=4; digest=ab7192d2b11f51c7…6558eb52d760.
3. s_null&s_last only -> k_reset pulse, then a single word k_in=0, is_last=1, byte_num=0; digest=0eab42de4c3ceb92…33d3670680e.
4. 8-byte message 12 34 56 78 90 AB CD EF with s_last on the 8th byte -> word 0x1234567890ABCDEF with is_last=0, then a zero word with is_last=1 and byte_num=0. Exactly 2 transfers.
5. k_buffer_full forced high for 10 cycles during SEND -> k_in, k_in_ready and k_is_last are unchanged and s_ready=0 throughout. Exactly one transfer occurs after release.
6. reset_n pulsed low after 5 bytes -> all outputs return to reset values immediately. A following full message hashes correctly, with a fresh k_reset and the expected digest.
